mips_pipe_core: RTL and testbench
=================================

# mips_pipe_core

Parametrised three-stage pipelined MIPS execution core: register file, ALU and data memory behind a valid/ready instruction port, with retire reporting. Successor to the single-cycle datapath: generalised datapath width, register count and memory depth, and adds pipelining, hazard handling, address checking and an observable retire stream. Sits between instruction fetch (upstream) and the verification scoreboard / debug tap (downstream).

## Interface
- WIDTH, 32, datapath and register width; minimum 16.
- NREGS, 32, architectural registers; 5-bit register fields are truncated to clog2(NREGS) bits.
- MEM_DEPTH, 256, data memory words; power of two.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  core accepts when instr_valid & instr_ready.
- instruction  in  32  MIPS encoding.
- retire_valid  out  1  one-cycle pulse per retired instruction.
- retire_we  out  1  retired instruction wrote a register.
- retire_rd  out  5  destination register; 0 when retire_we=0.
- retire_data  out  WIDTH  written value (lw/ALU) or store data (sw).
- err_illegal  out  1  one-cycle pulse in place of a retire for an unsupported encoding.
- err_addr  out  1  one-cycle pulse alongside the retire of a faulting lw/sw.

## Operation
- Supported instructions:
  - R-type (opcode 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I-type: addi 0x08, lw 0x23, sw 0x2B.
  - Everything else is illegal: it flows as a no-op, pulses err_illegal at its retire slot, and leaves retire_valid=0.
- Stages:
  - ID: register read, decode.
  - EX: ALU.
  - MEM: memory access. Register-file write occurs on the edge leaving MEM.
- Arithmetic:
  - add/sub/addi wrap modulo 2^WIDTH; there is no overflow trap.
  - slt is signed.
  - Immediates are sign-extended to WIDTH.
- Register 0 reads 0. Writes to rd=0 are discarded; the instruction still retires with retire_we=0.
- Address computation: byte address = rs + sext(imm); word index = addr[clog2(MEM_DEPTH)+1:2].
- Address fault: addr[1:0] != 0, or addr >= 4*MEM_DEPTH. On a fault:
  - The access is suppressed.
  - A faulting lw writes 0 to rt.
  - err_addr pulses alongside the retire.
- Memory is synchronous-read: the address is presented at the EX->MEM edge and data is valid in MEM.
- Reset values:
  - Every register-file entry, pipeline valid and output is 0.
  - Memory contents are not reset.
  - instr_ready is 0 while reset is high and 1 in the first cycle after.
- Reset mid-operation: all in-flight instructions are dropped. They produce no retire, no register write and no memory write.

## Timing
- Acceptance at edge T: the instruction occupies ID in cycle T+1, EX in T+2 and MEM in T+3.
- The register file and the retire outputs are updated at edge T+3. retire_valid is high in the cycle following that edge.
- Back-to-back acceptance sustains one retire per cycle in the absence of stalls.
- Retires are in order. Bubbles (no instr_valid) retire nothing.
- During a stall, instr_ready=0, ID holds its instruction, and a bubble enters EX.
- instr_ready depends only on internal state, not on instr_valid.

## Configuration
- MIPS_PIPE_FORWARD_EN defined:
  - MEM-stage result (ALU or load data) forwards to EX operands.
  - The register-file write data bypasses into ID reads of the same register (write-through).
  - There are no stalls.
- MIPS_PIPE_FORWARD_EN undefined:
  - ID stalls while any EX or MEM instruction will write a non-zero register read by ID (rs always; rt for R-type and sw).
  - The write-through bypass is retained.
  - A dependent instruction directly behind its producer stalls 2 cycles; one with a gap of one instruction stalls 1 cycle.

## Test plan
- Reset, then accept addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 back-to-back:
  - Retires report $1=5, $2=0xFFFF_FFFD, $3=2.
  - The retires occur in 3 consecutive cycles with forwarding; the $3 retire slips 2 cycles without it.
- sw $1,8($0) then lw $4,8($0) then addi $5,$4,1:
  - $4=5, $5=6.
  - sw retire shows retire_we=0, retire_data=5.
- lw $6,2($0) (misaligned) and lw $6,1024($0) with MEM_DEPTH=256:
  - Each retires $6=0 with err_addr=1.
  - Memory is unchanged.
- Instruction 0xFC000000 (opcode 0x3F), then addi $0,$0,7:
  - The first pulses err_illegal with retire_valid=0.
  - The second retires with retire_we=0 and $0 still reads 0.
- Assert reset for 1 cycle while three instructions are in flight:
  - No retire_valid occurs.
  - All registers read 0 afterwards.
  - instr_ready is 0 during reset and 1 after.
- slt $7,$2,$1 with $2=-3, $1=5:
  - $7=1.
  - sub $8,$2,$1 gives 0xFFFF_FFF8.
  - With WIDTH=16, the result is 0xFFF8.

Source files
------------

// File: rtl/mips_pipe_core.sv
// mips_pipe_core: three-stage (ID/EX/MEM) MIPS execution core with a retire stream.
// Build option: define MIPS_PIPE_FORWARD_EN for MEM->EX forwarding and a stall-free ID.
module mips_pipe_core #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instruction,
    output logic             retire_valid,
    output logic             retire_we,
    output logic [4:0]       retire_rd,
    output logic [WIDTH-1:0] retire_data,
    output logic             err_illegal,
    output logic             err_addr
);
    localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

    // Architectural state
    logic [WIDTH-1:0] rf_q   [NREGS];
    logic [WIDTH-1:0] dmem_q [MEM_DEPTH];

    // ID stage
    logic             id_valid_q;
    logic [31:0]      id_instr_q;
    logic [5:0]       id_op, id_funct;
    logic [RW-1:0]    id_rs, id_rt, id_rd, id_dst;
    logic             id_rtype, id_lw, id_sw, id_addi, id_r_legal, id_legal, id_we;
    alu_op_e          id_alu_op;
    logic [WIDTH-1:0] id_a, id_b, id_imm;
    logic             stall;

    // EX stage
    logic             ex_valid_q, ex_illegal_q, ex_we_q, ex_lw_q, ex_sw_q, ex_use_imm_q;
    alu_op_e          ex_alu_op_q;
    logic [RW-1:0]    ex_rd_q;
    logic [WIDTH-1:0] ex_a_q, ex_b_q, ex_imm_q;
    logic [WIDTH-1:0] ex_a, ex_b, ex_opb, ex_alu, ex_addr;
    logic             ex_fault;
    logic [AW-1:0]    ex_idx;

    // MEM stage
    logic             mem_valid_q, mem_illegal_q, mem_we_q, mem_lw_q, mem_sw_q, mem_fault_q;
    logic [RW-1:0]    mem_rd_q;
    logic [WIDTH-1:0] mem_alu_q, mem_store_q, mem_rdata_q, mem_result;
    logic [AW-1:0]    mem_idx_q;
    logic             wb_we;

    logic unused_shamt;
    assign unused_shamt = ^id_instr_q[10:6];

    // ---------------------------------------------------------------- ID decode
    assign id_op    = id_instr_q[31:26];
    assign id_funct = id_instr_q[5:0];
    assign id_rs    = id_instr_q[21 +: RW];
    assign id_rt    = id_instr_q[16 +: RW];
    assign id_rd    = id_instr_q[11 +: RW];
    assign id_imm   = WIDTH'($signed(id_instr_q[15:0]));

    always_comb begin
        id_rtype   = (id_op == 6'h00);
        id_addi    = (id_op == 6'h08);
        id_lw      = (id_op == 6'h23);
        id_sw      = (id_op == 6'h2B);
        id_alu_op  = AluAdd;
        id_r_legal = 1'b0;
        case (id_funct)
            6'h20: begin id_alu_op = AluAdd; id_r_legal = 1'b1; end
            6'h22: begin id_alu_op = AluSub; id_r_legal = 1'b1; end
            6'h24: begin id_alu_op = AluAnd; id_r_legal = 1'b1; end
            6'h25: begin id_alu_op = AluOr;  id_r_legal = 1'b1; end
            6'h2A: begin id_alu_op = AluSlt; id_r_legal = 1'b1; end
            default: ;
        endcase
        if (!id_rtype) id_alu_op = AluAdd;
        id_legal = (id_rtype & id_r_legal) | id_addi | id_lw | id_sw;
        id_dst   = id_rtype ? id_rd : id_rt;
        id_we    = id_legal & ~id_sw & (id_dst != '0);
    end

    // Register read with write-through of the value retiring this cycle
    assign wb_we = mem_valid_q & mem_we_q;

    always_comb begin
        id_a = rf_q[id_rs];
        id_b = rf_q[id_rt];
        if (wb_we && mem_rd_q == id_rs) id_a = mem_result;
        if (wb_we && mem_rd_q == id_rt) id_b = mem_result;
        if (id_rs == '0) id_a = '0;
        if (id_rt == '0) id_b = '0;
    end

`ifdef MIPS_PIPE_FORWARD_EN
    logic [RW-1:0] ex_rs_q, ex_rt_q;
    assign stall = 1'b0;
`else
    logic id_uses_rt, haz_ex, haz_mem;
    assign id_uses_rt = id_rtype | id_sw;
    // ex/mem_we_q already exclude register 0
    assign haz_ex  = ex_valid_q & ex_we_q &
                     ((ex_rd_q == id_rs) | (id_uses_rt & (ex_rd_q == id_rt)));
    assign haz_mem = mem_valid_q & mem_we_q &
                     ((mem_rd_q == id_rs) | (id_uses_rt & (mem_rd_q == id_rt)));
    assign stall   = id_valid_q & (haz_ex | haz_mem);
`endif

    assign instr_ready = ~reset & ~stall;

    // ---------------------------------------------------------------- EX
    always_comb begin
        ex_a = ex_a_q;
        ex_b = ex_b_q;
`ifdef MIPS_PIPE_FORWARD_EN
        if (wb_we && mem_rd_q == ex_rs_q) ex_a = mem_result;
        if (wb_we && mem_rd_q == ex_rt_q) ex_b = mem_result;
`endif
        ex_opb = ex_use_imm_q ? ex_imm_q : ex_b;
        case (ex_alu_op_q)
            AluSub:  ex_alu = ex_a - ex_opb;
            AluAnd:  ex_alu = ex_a & ex_opb;
            AluOr:   ex_alu = ex_a | ex_opb;
            AluSlt:  ex_alu = WIDTH'($signed(ex_a) < $signed(ex_opb));
            default: ex_alu = ex_a + ex_opb;
        endcase
        ex_addr  = ex_a + ex_imm_q;
        ex_fault = (ex_lw_q | ex_sw_q) &
                   ((ex_addr[1:0] != 2'b00) | ((ex_addr >> (AW + 2)) != '0));
        ex_idx   = ex_addr[AW+1:2];
    end

    // ---------------------------------------------------------------- MEM
    assign mem_result = mem_lw_q ? (mem_fault_q ? '0 : mem_rdata_q) : mem_alu_q;

    // Stores commit on the edge leaving MEM; a load right behind sees the store data.
    always_ff @(posedge clock) begin
        if (!reset && mem_valid_q && mem_sw_q && !mem_fault_q) begin
            dmem_q[mem_idx_q] <= mem_store_q;
        end
        if (mem_valid_q && mem_sw_q && !mem_fault_q && mem_idx_q == ex_idx) begin
            mem_rdata_q <= mem_store_q;
        end else begin
            mem_rdata_q <= dmem_q[ex_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_we) begin
            rf_q[mem_rd_q] <= mem_result;
        end
    end

    // ---------------------------------------------------------------- pipeline registers
    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            ex_valid_q    <= 1'b0;
            ex_illegal_q  <= 1'b0;
            ex_we_q       <= 1'b0;
            ex_lw_q       <= 1'b0;
            ex_sw_q       <= 1'b0;
            ex_use_imm_q  <= 1'b0;
            ex_alu_op_q   <= AluAdd;
            ex_rd_q       <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_imm_q      <= '0;
            mem_valid_q   <= 1'b0;
            mem_illegal_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_lw_q      <= 1'b0;
            mem_sw_q      <= 1'b0;
            mem_fault_q   <= 1'b0;
            mem_rd_q      <= '0;
            mem_alu_q     <= '0;
            mem_store_q   <= '0;
            mem_idx_q     <= '0;
            retire_valid  <= 1'b0;
            retire_we     <= 1'b0;
            retire_rd     <= '0;
            retire_data   <= '0;
            err_illegal   <= 1'b0;
            err_addr      <= 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                id_valid_q <= 1'b1;
                id_instr_q <= instruction;
            end else if (!stall) begin
                id_valid_q <= 1'b0;
            end

            ex_valid_q   <= id_valid_q & ~stall;
            ex_illegal_q <= ~id_legal;
            ex_we_q      <= id_we;
            ex_lw_q      <= id_lw;
            ex_sw_q      <= id_sw;
            ex_use_imm_q <= ~id_rtype;
            ex_alu_op_q  <= id_alu_op;
            ex_rd_q      <= id_dst;
            ex_a_q       <= id_a;
            ex_b_q       <= id_b;
            ex_imm_q     <= id_imm;

            mem_valid_q   <= ex_valid_q;
            mem_illegal_q <= ex_illegal_q;
            mem_we_q      <= ex_we_q;
            mem_lw_q      <= ex_lw_q;
            mem_sw_q      <= ex_sw_q;
            mem_fault_q   <= ex_fault;
            mem_rd_q      <= ex_rd_q;
            mem_alu_q     <= ex_alu;
            mem_store_q   <= ex_b;
            mem_idx_q     <= ex_idx;

            retire_valid <= mem_valid_q & ~mem_illegal_q;
            err_illegal  <= mem_valid_q & mem_illegal_q;
            err_addr     <= mem_valid_q & mem_fault_q;
            retire_we    <= wb_we;
            retire_rd    <= wb_we ? 5'(mem_rd_q) : 5'd0;
            if (!mem_valid_q || mem_illegal_q) begin
                retire_data <= '0;
            end else begin
                retire_data <= mem_sw_q ? mem_store_q : mem_result;
            end
        end
    end

`ifdef MIPS_PIPE_FORWARD_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= id_rs;
            ex_rt_q <= id_rt;
        end
    end
`endif

endmodule

// File: tb/tb_mips_pipe_core.sv
// Bench for mips_pipe_core: expected retire events are queued as instructions are issued and
// compared in order against the observed retire stream; a WIDTH=16 copy checks narrow arithmetic.
`timescale 1ns/1ps
module tb_mips_pipe_core;
    typedef struct packed {
        logic        rv;
        logic        il;
        logic        ea;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } ev_t;

    localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnOr = 6'h25, FnSlt = 6'h2A;
    localparam logic [5:0] OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2B;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_ready, retire_valid, retire_we, err_illegal, err_addr;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        n_ready, n_rv, n_we, n_il, n_ea;
    logic [4:0]  n_rd;
    logic [15:0] n_data;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    int cyc_q[$];
    logic [15:0] obs16_q[$];

    mips_pipe_core dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .retire_valid(retire_valid), .retire_we(retire_we),
        .retire_rd(retire_rd), .retire_data(retire_data), .err_illegal(err_illegal),
        .err_addr(err_addr)
    );

    mips_pipe_core #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(n_ready),
        .instruction(instruction), .retire_valid(n_rv), .retire_we(n_we),
        .retire_rd(n_rd), .retire_data(n_data), .err_illegal(n_il), .err_addr(n_ea)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    always @(negedge clock) begin
        ev_t e;
        e = {retire_valid, err_illegal, err_addr, retire_we, retire_rd, retire_data};
        if (retire_valid || err_illegal || err_addr) begin
            obs_q.push_back(e);
            cyc_q.push_back(cycle);
        end
        if (n_rv) obs16_q.push_back(n_data);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic ev_t ev(input logic rv, input logic il, input logic ea, input logic we,
                               input int rd, input logic [31:0] data);
        return {rv, il, ea, we, 5'(rd), data};
    endfunction

    // Offers one instruction starting at a falling edge; returns at the falling edge after it
    // was accepted.
    task automatic issue(input logic [31:0] ins);
        int k;
        instr_valid = 1'b1;
        instruction = ins;
        k = 0;
        while (!instr_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (k >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout ready=%0b required=1 instr=%h", instr_ready, ins);
        end
        @(negedge clock);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if (instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got=%0b required=0", instr_ready);
        end
        outs = {retire_valid, retire_we, retire_rd, retire_data, err_illegal, err_addr};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h required=0", outs);
        end
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready got=%0b required=1", instr_ready);
        end
        vectors++;
        if (obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_no_retire got=%0d required=0", obs_q.size());
        end
        obs_q.delete();
        cyc_q.delete();
    endtask

    task automatic test_back_to_back();
        int gap_exp;
        ev_t e, o;
`ifdef MIPS_PIPE_FORWARD_EN
        gap_exp = 1;
`else
        gap_exp = 3;
`endif
        cyc_q.delete();
        issue(i_op(OpAddi, 0, 1, 16'd5));      exp_q.push_back(ev(1, 0, 0, 1, 1, 32'd5));
        issue(i_op(OpAddi, 0, 2, 16'hFFFD));   exp_q.push_back(ev(1, 0, 0, 1, 2, 32'hFFFF_FFFD));
        issue(r_op(1, 2, 3, FnAdd));           exp_q.push_back(ev(1, 0, 0, 1, 3, 32'd2));
        repeat (12) @(negedge clock);
        if (cyc_q.size() == 3) begin
            vectors++;
            if (cyc_q[1] - cyc_q[0] !== 1) begin
                miscompares++;
                $display("FAIL b2b_gap1 got=%0d required=1", cyc_q[1] - cyc_q[0]);
            end
            vectors++;
            if (cyc_q[2] - cyc_q[1] !== gap_exp) begin
                miscompares++;
                $display("FAIL b2b_gap2 got=%0d required=%0d", cyc_q[2] - cyc_q[1], gap_exp);
            end
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL b2b_retire got=%h required=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_mem();
        ev_t e, o;
        issue(i_op(OpSw, 0, 1, 16'd8));        exp_q.push_back(ev(1, 0, 0, 0, 0, 32'd5));
        issue(i_op(OpLw, 0, 4, 16'd8));        exp_q.push_back(ev(1, 0, 0, 1, 4, 32'd5));
        issue(i_op(OpAddi, 4, 5, 16'd1));      exp_q.push_back(ev(1, 0, 0, 1, 5, 32'd6));
        repeat (12) @(negedge clock);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL mem_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mem_retire got=%h required=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_addr_fault();
        ev_t e, o;
        issue(i_op(OpSw, 0, 1, 16'd0));        exp_q.push_back(ev(1, 0, 0, 0, 0, 32'd5));
        issue(i_op(OpLw, 0, 6, 16'd2));        exp_q.push_back(ev(1, 0, 1, 1, 6, 32'd0));
        issue(i_op(OpLw, 0, 6, 16'd1024));     exp_q.push_back(ev(1, 0, 1, 1, 6, 32'd0));
        issue(i_op(OpSw, 0, 2, 16'd1024));     exp_q.push_back(ev(1, 0, 1, 0, 0, 32'hFFFF_FFFD));
        issue(i_op(OpLw, 0, 12, 16'd0));       exp_q.push_back(ev(1, 0, 0, 1, 12, 32'd5));
        issue(i_op(OpLw, 0, 13, 16'd8));       exp_q.push_back(ev(1, 0, 0, 1, 13, 32'd5));
        repeat (12) @(negedge clock);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL fault_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL fault_retire got=%h required=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_illegal();
        ev_t e, o;
        issue(32'hFC00_0000);                  exp_q.push_back(ev(0, 1, 0, 0, 0, 32'd0));
        issue(i_op(OpAddi, 0, 0, 16'd7));      exp_q.push_back(ev(1, 0, 0, 0, 0, 32'd7));
        issue(r_op(0, 0, 11, FnOr));           exp_q.push_back(ev(1, 0, 0, 1, 11, 32'd0));
        repeat (12) @(negedge clock);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL illegal_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL illegal_retire got=%h required=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_mid_reset();
        ev_t e, o;
        issue(i_op(OpAddi, 0, 14, 16'd9));
        issue(i_op(OpAddi, 0, 15, 16'd1));
        issue(i_op(OpAddi, 0, 16, 16'd2));
        reset = 1'b1;
        #1;
        vectors++;
        if (instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_ready got=%0b required=0", instr_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_release_ready got=%0b required=1", instr_ready);
        end
        repeat (10) @(negedge clock);
        vectors++;
        if (obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL midreset_retired got=%0d required=0", obs_q.size());
        end
        obs_q.delete();
        for (int r = 1; r < 32; r++) begin
            issue(r_op(r, 0, r, FnOr));
            exp_q.push_back(ev(1, 0, 0, 1, r, 32'd0));
        end
        repeat (12) @(negedge clock);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL regs_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL regs_after_reset got=%h required=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_slt_sub();
        ev_t e, o;
        logic [15:0] exp16[$];
        logic [15:0] n;
        obs16_q.delete();
        issue(i_op(OpAddi, 0, 1, 16'd5));    exp_q.push_back(ev(1, 0, 0, 1, 1, 32'd5));
        exp16.push_back(16'd5);
        issue(i_op(OpAddi, 0, 2, 16'hFFFD)); exp_q.push_back(ev(1, 0, 0, 1, 2, 32'hFFFF_FFFD));
        exp16.push_back(16'hFFFD);
        issue(r_op(2, 1, 7, FnSlt));         exp_q.push_back(ev(1, 0, 0, 1, 7, 32'd1));
        exp16.push_back(16'd1);
        issue(r_op(2, 1, 8, FnSub));         exp_q.push_back(ev(1, 0, 0, 1, 8, 32'hFFFF_FFF8));
        exp16.push_back(16'hFFF8);
        issue(r_op(1, 2, 9, FnSlt));         exp_q.push_back(ev(1, 0, 0, 1, 9, 32'd0));
        exp16.push_back(16'd0);
        repeat (12) @(negedge clock);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL slt_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL slt_sub_retire got=%h required=%h", o, e);
            end
        end
        vectors++;
        if (obs16_q.size() !== exp16.size()) begin
            miscompares++;
            $display("FAIL w16_count got=%0d required=%0d", obs16_q.size(), exp16.size());
        end
        while (exp16.size() > 0 && obs16_q.size() > 0) begin
            n = obs16_q.pop_front();
            vectors++;
            if (n !== exp16[0]) begin
                miscompares++;
                $display("FAIL w16_data got=%h required=%h", n, exp16[0]);
            end
            void'(exp16.pop_front());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mem();
        test_addr_fault();
        test_illegal();
        test_mid_reset();
        test_slt_sub();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
